// File: rtl/my_op_accumulator_pkg.sv
// Shared encodings for the operand accumulator: FSM states and operand selects.
package MyOpPkg;

  // IDLE: empty block, ACCUM: partially filled block, DONE: holding a finished sum
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SEL_ADD  = 2'd0;
  localparam logic [1:0] SEL_SUB  = 2'd1;
  localparam logic [1:0] SEL_MUL  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

endpackage

// File: rtl/my_op_accumulator.sv
// Block accumulator: sums LEN selected operator results per block, then
// offers the sum on a valid/ready output and waits for the handoff.
module my_op_accumulator
  import MyOpPkg::*;
#(
  parameter int LEN   = 8,
  parameter int ACC_W = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_clear,
  input  logic [1:0]       io_sel,
  input  logic [3:0]       io_in_add,
  input  logic [3:0]       io_in_sub,
  input  logic [7:0]       io_in_mul,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  output logic [ACC_W-1:0] io_out_sum,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [3:0]       io_count,
  output logic             io_overflow
);

  // Count value before the transfer that completes a block.
  localparam logic [3:0] LAST_COUNT = 4'(LEN - 1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [3:0]       count_reg, count_next;
  logic             overflow_reg, overflow_next;

  logic [ACC_W-1:0] operand;
  logic [ACC_W:0]   sum_ext;
  logic             transfer;

  // Outputs decode directly from the registered state so async reset is seen at once.
  assign io_in_ready  = (state_reg != DONE);
  assign io_out_valid = (state_reg == DONE);
  assign io_out_sum   = io_out_valid ? acc_reg : '0;
  assign io_count     = count_reg;
  assign io_overflow  = overflow_reg;

  assign transfer = io_in_valid && io_in_ready;

  // Operand mux: selected result zero-extended to the accumulator width.
  always_comb begin
    operand = '0;
    case (io_sel)
      SEL_ADD:  operand = ACC_W'(io_in_add);
      SEL_SUB:  operand = ACC_W'(io_in_sub);
      SEL_MUL:  operand = ACC_W'(io_in_mul);
      default:  operand = '0;
    endcase
  end

  // One extra bit on the adder exposes the carry-out for the sticky overflow.
  assign sum_ext = {1'b0, acc_reg} + {1'b0, operand};

  // Next-state logic; clear overrides any transfer or handoff in the same cycle.
  always_comb begin
    state_next    = state_reg;
    acc_next      = acc_reg;
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (io_clear) begin
      state_next    = IDLE;
      acc_next      = '0;
      count_next    = '0;
      overflow_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE, ACCUM: begin
          if (transfer) begin
            acc_next      = sum_ext[ACC_W-1:0];
            overflow_next = overflow_reg | sum_ext[ACC_W];
            count_next    = count_reg + 4'd1;
            state_next    = (count_reg == LAST_COUNT) ? DONE : ACCUM;
          end
        end
        DONE: begin
          if (io_out_ready) begin
            state_next    = IDLE;
            acc_next      = '0;
            count_next    = '0;
            overflow_next = 1'b0;
          end
        end
        default: begin
          state_next    = IDLE;
          acc_next      = '0;
          count_next    = '0;
          overflow_next = 1'b0;
        end
      endcase
    end
  end

  // State registers with asynchronous reset to an empty block.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      acc_reg      <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      acc_reg      <= acc_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

endmodule

// File: tb/tb_my_op_accumulator.sv
// Directed bench for my_op_accumulator with a queue scoreboard of expected sums.
module tb_my_op_accumulator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;

  // Main instance (defaults: LEN=8, ACC_W=12)
  logic        clear = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [3:0]  in_add = '0, in_sub = '0;
  logic [7:0]  in_mul = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] out_sum;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  count;
  logic        overflow;

  // Small instance for the overflow case (LEN=2, ACC_W=8)
  logic        o_clear = 1'b0;
  logic [1:0]  o_sel = 2'd0;
  logic [3:0]  o_add = '0, o_sub = '0;
  logic [7:0]  o_mul = '0;
  logic        o_in_valid = 1'b0;
  logic        o_in_ready;
  logic [7:0]  o_out_sum;
  logic        o_out_valid;
  logic        o_out_ready = 1'b0;
  logic [3:0]  o_count;
  logic        o_overflow;

  int tests = 0;
  int fails = 0;
  int unsigned exp_q[$];
  int unsigned exp_sum;
  int unsigned popped;

  always #5 clock = ~clock;

  my_op_accumulator dut (
    .clock(clock), .reset(reset), .io_clear(clear), .io_sel(sel),
    .io_in_add(in_add), .io_in_sub(in_sub), .io_in_mul(in_mul),
    .io_in_valid(in_valid), .io_in_ready(in_ready),
    .io_out_sum(out_sum), .io_out_valid(out_valid), .io_out_ready(out_ready),
    .io_count(count), .io_overflow(overflow)
  );

  my_op_accumulator #(.LEN(2), .ACC_W(8)) dut_ov (
    .clock(clock), .reset(reset), .io_clear(o_clear), .io_sel(o_sel),
    .io_in_add(o_add), .io_in_sub(o_sub), .io_in_mul(o_mul),
    .io_in_valid(o_in_valid), .io_in_ready(o_in_ready),
    .io_out_sum(o_out_sum), .io_out_valid(o_out_valid), .io_out_ready(o_out_ready),
    .io_count(o_count), .io_overflow(o_overflow)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
    $display("[TB] check %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  // Wait (bounded) for a completed block, then compare it against the scoreboard head.
  task automatic expect_out(input string tag);
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      popped = exp_q.pop_front();
      check({tag, "_sum"}, 32'(out_sum), popped);
    end
  endtask

  initial begin
    // Power-up reset, released mid-cycle
    #12;
    reset = 1'b0;
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_sum", 32'(out_sum), 32'd0);

    // Eight back-to-back mul=225 transfers, output always ready
    out_ready = 1'b1;
    sel = 2'd2; in_mul = 8'd225; in_valid = 1'b1;
    exp_q.push_back(32'd1800);
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    expect_out("mul_blk");
    check("mul_blk_ovf", 32'(overflow), 32'd0);
    check("mul_blk_count", 32'(count), 32'd8);
    tick();
    check("mul_blk_valid_drop", 32'(out_valid), 32'd0);
    check("mul_blk_count_zero", 32'(count), 32'd0);

    // Mixed random selects, including sub and none
    exp_sum = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel    = 2'($urandom_range(0, 3));
      in_add = 4'($urandom_range(0, 15));
      in_sub = 4'($urandom_range(0, 15));
      in_mul = 8'($urandom_range(0, 255));
      case (sel)
        2'd0: exp_sum += in_add;
        2'd1: exp_sum += in_sub;
        2'd2: exp_sum += in_mul;
        default: exp_sum += 0;
      endcase
      tick();
    end
    exp_q.push_back(exp_sum % 4096);
    in_valid = 1'b0;
    expect_out("mix_blk");
    tick();

    // Backpressure: block of add=3 held for 5 cycles with input valid asserted
    out_ready = 1'b0;
    sel = 2'd0; in_add = 4'd3; in_valid = 1'b1;
    exp_q.push_back(32'd24);
    for (int i = 0; i < 8; i++) tick();
    expect_out("bp_blk");
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_sum", 32'(out_sum), 32'd24);
      check("bp_hold_count", 32'(count), 32'd8);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", 32'(out_valid), 32'd0);
    check("bp_release_count", 32'(count), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);

    // Overflow on the small instance: 200 + 200 = 400 -> 144 with carry
    o_sel = 2'd2; o_mul = 8'd200; o_in_valid = 1'b1;
    tick();
    check("ov_first_count", 32'(o_count), 32'd1);
    check("ov_first_flag", 32'(o_overflow), 32'd0);
    tick();
    o_in_valid = 1'b0;
    check("ov_valid", 32'(o_out_valid), 32'd1);
    check("ov_sum", 32'(o_out_sum), 32'd144);
    check("ov_flag", 32'(o_overflow), 32'd1);
    o_out_ready = 1'b1;
    tick();
    check("ov_flag_cleared", 32'(o_overflow), 32'd0);

    // Clear in the same cycle as a 4th transfer discards it
    sel = 2'd0; in_add = 4'd5; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("clr_pre_count", 32'(count), 32'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    in_valid = 1'b0;
    check("clr_count", 32'(count), 32'd0);
    check("clr_sum", 32'(out_sum), 32'd0);
    check("clr_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b0;
    in_add = 4'd1; in_valid = 1'b1;
    exp_q.push_back(32'd8);
    for (int i = 0; i < 8; i++) tick();
    in_valid = 1'b0;
    expect_out("clr_follow");

    // Async reset mid-cycle while holding DONE
    #3;
    reset = 1'b1;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_sum", 32'(out_sum), 32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    #2;
    reset = 1'b0;
    sel = 2'd0; in_add = 4'd4; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("post_rst_transfer_count", 32'(count), 32'd1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
